// File: rtl/lab3_mem_pkg.sv
// Shared definitions for the line-granular memory responder: message types,
// line geometry and the responder FSM state encoding.
package lab3_mem_pkg;

  localparam logic [2:0] MEM_READ  = 3'd0;
  localparam logic [2:0] MEM_WRITE = 3'd1;
  localparam logic [2:0] MEM_INIT  = 3'd2;

  localparam int unsigned LINE_NBITS  = 128;
  localparam int unsigned LINE_NBYTES = 16;
  localparam int unsigned TYPE_NBITS  = 3;
  localparam int unsigned LEN_NBITS   = 4;
  localparam int unsigned ADDR_NBITS  = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_e;

endpackage

// File: rtl/lab3_mem_line_store.sv
// Line storage: nlines x 128-bit register array, one combinational read port
// and one synchronous write port. Deliberately not reset.
module lab3_mem_line_store
  import lab3_mem_pkg::*;
#(
  parameter int unsigned NLines = 64,
  localparam int unsigned IdxW  = $clog2(NLines)
) (
  input  logic                  clk_i,
  input  logic [IdxW-1:0]       rd_idx_i,
  output logic [LINE_NBITS-1:0] rd_data_o,
  input  logic                  wr_en_i,
  input  logic [IdxW-1:0]       wr_idx_i,
  input  logic [LINE_NBITS-1:0] wr_data_i
);

  logic [LINE_NBITS-1:0] lines_q [NLines];

  assign rd_data_o = lines_q[rd_idx_i];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      lines_q[wr_idx_i] <= wr_data_i;
    end
  end

endmodule

// File: rtl/lab3_mem_line_mem_responder.sv
// Line-granular memory responder: accepts one READ/WRITE/INIT line request at a
// time and answers after p_latency wait cycles over a val/rdy response channel.
module lab3_mem_line_mem_responder
  import lab3_mem_pkg::*;
#(
  parameter int unsigned p_mem_nbytes   = 1024,
  parameter int unsigned p_opaque_nbits = 8,
  parameter int unsigned p_latency      = 2,
  localparam int unsigned clw        = LINE_NBITS,
  localparam int unsigned abw        = ADDR_NBITS,
  localparam int unsigned nlines     = p_mem_nbytes / LINE_NBYTES,
  localparam int unsigned idw        = $clog2(nlines),
  localparam int unsigned req_nbits  = TYPE_NBITS + p_opaque_nbits + abw + LEN_NBITS + clw,
  localparam int unsigned resp_nbits = TYPE_NBITS + p_opaque_nbits + LEN_NBITS + clw
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [req_nbits-1:0]  memreq_msg,
  input  logic                  memreq_val,
  output logic                  memreq_rdy,
  output logic [resp_nbits-1:0] memresp_msg,
  output logic                  memresp_val,
  input  logic                  memresp_rdy
);

  // Request message layout, MSB first: type | opaque | addr | len | data.
  logic [TYPE_NBITS-1:0]     req_type;
  logic [p_opaque_nbits-1:0] req_opaque;
  logic [abw-1:0]            req_addr;
  logic [LEN_NBITS-1:0]      req_len;
  logic [clw-1:0]            req_data;

  assign {req_type, req_opaque, req_addr, req_len, req_data} = memreq_msg;

  logic [idw-1:0] req_idx;
  assign req_idx = req_addr[idw+3:4];

  // Offset, high address bits and len are ignored: every access is a full line.
  logic unused_req_bits;
  assign unused_req_bits = ^{req_len, req_addr[abw-1:idw+4], req_addr[3:0]};

  state_e                    state_q, state_d;
  logic [3:0]                cnt_q, cnt_d;
  logic [TYPE_NBITS-1:0]     type_q, type_d;
  logic [p_opaque_nbits-1:0] opaque_q, opaque_d;
  logic [clw-1:0]            data_q, data_d;
  logic                      st_wr_en;
  logic [clw-1:0]            st_rd_data;

  lab3_mem_line_store #(
    .NLines(nlines)
  ) u_line_store (
    .clk_i    (clk),
    .rd_idx_i (req_idx),
    .rd_data_o(st_rd_data),
    .wr_en_i  (st_wr_en),
    .wr_idx_i (req_idx),
    .wr_data_i(req_data)
  );

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    type_d      = type_q;
    opaque_d    = opaque_q;
    data_d      = data_q;
    st_wr_en    = 1'b0;
    memreq_rdy  = 1'b0;
    memresp_val = 1'b0;
    unique case (state_q)
      IDLE: begin
        memreq_rdy = !reset;
        if (memreq_val && !reset) begin
          type_d   = req_type;
          opaque_d = req_opaque;
          cnt_d    = 4'(p_latency);
          // Unknown types behave as READ but return zero data.
          data_d   = (req_type == MEM_READ) ? st_rd_data : '0;
          st_wr_en = (req_type == MEM_WRITE) || (req_type == MEM_INIT);
          state_d  = (p_latency > 0) ? WAIT : RESP;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q <= 4'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        memresp_val = 1'b1;
        if (memresp_rdy) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      type_q   <= '0;
      opaque_q <= '0;
      data_q   <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      type_q   <= type_d;
      opaque_q <= opaque_d;
      data_q   <= data_d;
    end
  end

  assign memresp_msg = {type_q, opaque_q, {LEN_NBITS{1'b0}}, data_q};

endmodule

// File: tb/tb_lab3_mem_line_mem_responder.sv
// Bench for the line memory responder: two instances (latency 0 and 3) share
// the request bus; sel picks the instance under test.
module tb_lab3_mem_line_mem_responder;

  typedef struct packed {
    logic [2:0]   t;
    logic [7:0]   op;
    logic [127:0] data;
  } exp_t;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic [174:0] req_msg = '0;
  logic         req_val = 1'b0;
  logic         resp_rdy = 1'b0;
  logic         sel = 1'b0;

  logic         rdy0, rdy3, val0, val3;
  logic [142:0] msg0, msg3;
  logic         dut_rdy, dut_val;
  logic [142:0] dut_msg;

  int n_tests = 0;
  int n_fail  = 0;

  exp_t         sb [$];
  logic [127:0] model [2][64];

  localparam logic [127:0] D_INIT = 128'h0123456789ABCDEF0123456789ABCDEF;
  localparam logic [127:0] D_AAAA = {8{16'hAAAA}};
  localparam logic [127:0] D0     = 128'h00000000_11111111_22222222_33333333;
  localparam logic [127:0] D1     = 128'hD1D1D1D1_CAFEF00D_12345678_9ABCDEF0;
  localparam logic [127:0] DX     = 128'hFEEDFACE_0BADBEEF_5555AAAA_C0FFEE00;

  always #5 clk = ~clk;

  assign dut_rdy = sel ? rdy3 : rdy0;
  assign dut_val = sel ? val3 : val0;
  assign dut_msg = sel ? msg3 : msg0;

  lab3_mem_line_mem_responder #(
    .p_mem_nbytes  (1024),
    .p_opaque_nbits(8),
    .p_latency     (0)
  ) u_dut0 (
    .clk        (clk),
    .reset      (reset),
    .memreq_msg (req_msg),
    .memreq_val (req_val && !sel),
    .memreq_rdy (rdy0),
    .memresp_msg(msg0),
    .memresp_val(val0),
    .memresp_rdy(resp_rdy)
  );

  lab3_mem_line_mem_responder #(
    .p_mem_nbytes  (1024),
    .p_opaque_nbits(8),
    .p_latency     (3)
  ) u_dut3 (
    .clk        (clk),
    .reset      (reset),
    .memreq_msg (req_msg),
    .memreq_val (req_val && sel),
    .memreq_rdy (rdy3),
    .memresp_msg(msg3),
    .memresp_val(val3),
    .memresp_rdy(resp_rdy)
  );

  // One full transaction; hold_bp stalls the response for 5 cycles.
  task automatic send(input logic [2:0] t, input logic [31:0] addr, input logic [7:0] op,
                      input logic [127:0] data, input bit hold_bp);
    int           cyc;
    int           lat_exp;
    int           idx;
    bit           rdy_bad;
    exp_t         e;
    logic [142:0] first_msg;
    lat_exp = sel ? 3 : 0;
    idx     = int'(addr[9:4]);
    rdy_bad = 1'b0;
    @(negedge clk);
    resp_rdy = 1'b0;
    req_msg  = {t, op, addr, 4'd0, data};
    req_val  = 1'b1;
    cyc = 0;
    while (!dut_rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (dut_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL accept_timeout: memreq_rdy=%b required 1", dut_rdy);
      req_val = 1'b0;
      return;
    end
    e.t    = t;
    e.op   = op;
    e.data = (t == 3'd0) ? model[sel][idx] : 128'd0;
    if (t == 3'd1 || t == 3'd2) model[sel][idx] = data;
    sb.push_back(e);
    @(posedge clk);
    #1 req_val = 1'b0;
    // Cycle in which val is first seen, counting the acceptance cycle as 0.
    cyc = 1;
    @(negedge clk);
    while (dut_val !== 1'b1 && cyc < 40) begin
      if (dut_rdy !== 1'b0) rdy_bad = 1'b1;
      @(negedge clk);
      cyc++;
    end
    n_tests++;
    if (cyc != lat_exp + 1) begin
      n_fail++;
      $display("FAIL latency: got %0d cycles required %0d", cyc, lat_exp + 1);
    end
    first_msg = dut_msg;
    if (dut_rdy !== 1'b0) rdy_bad = 1'b1;
    if (hold_bp) begin
      repeat (5) begin
        @(negedge clk);
        n_tests++;
        if (dut_val !== 1'b1 || dut_rdy !== 1'b0 || dut_msg !== first_msg) begin
          n_fail++;
          $display("FAIL backpressure_hold: val=%b rdy=%b msg=%h required val=1 rdy=0 msg=%h",
                   dut_val, dut_rdy, dut_msg, first_msg);
        end
      end
    end
    resp_rdy = 1'b1;
    #1;
    if (dut_rdy !== 1'b0) rdy_bad = 1'b1;
    n_tests++;
    if (rdy_bad) begin
      n_fail++;
      $display("FAIL req_rdy_busy: memreq_rdy seen 1 while busy, required 0");
    end
    n_tests++;
    if (sb.size() == 0) begin
      n_fail++;
      $display("FAIL scoreboard_empty: got response with no expected entry");
    end else begin
      e = sb.pop_front();
      if (dut_msg[142:140] !== e.t) begin
        n_fail++;
        $display("FAIL resp_type: got %0d required %0d", dut_msg[142:140], e.t);
      end
      n_tests++;
      if (dut_msg[139:132] !== e.op) begin
        n_fail++;
        $display("FAIL resp_opaque: got %h required %h", dut_msg[139:132], e.op);
      end
      n_tests++;
      if (dut_msg[131:128] !== 4'd0) begin
        n_fail++;
        $display("FAIL resp_len: got %0d required 0", dut_msg[131:128]);
      end
      n_tests++;
      if (dut_msg[127:0] !== e.data) begin
        n_fail++;
        $display("FAIL resp_data: got %h required %h", dut_msg[127:0], e.data);
      end
    end
    @(posedge clk);
    #1 resp_rdy = 1'b0;
    @(negedge clk);
    n_tests++;
    if (dut_val !== 1'b0 || dut_rdy !== 1'b1) begin
      n_fail++;
      $display("FAIL single_transfer: val=%b rdy=%b required val=0 rdy=1", dut_val, dut_rdy);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    n_tests++;
    if (val0 !== 1'b0 || val3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_val: got %b%b required 00", val0, val3);
    end
    n_tests++;
    if (rdy0 !== 1'b0 || rdy3 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_rdy: got %b%b required 00", rdy0, rdy3);
    end
    n_tests++;
    if (msg0 !== 143'd0 || msg3 !== 143'd0) begin
      n_fail++;
      $display("FAIL reset_msg: got %h / %h required 0", msg0, msg3);
    end
    reset = 1'b0;
    #1;
    n_tests++;
    if (rdy0 !== 1'b1 || rdy3 !== 1'b1) begin
      n_fail++;
      $display("FAIL rdy_after_reset: got %b%b required 11", rdy0, rdy3);
    end
  endtask

  task automatic test_latency0();
    sel = 1'b0;
    send(3'd2, 32'h0000_0100, 8'h11, D_INIT, 1'b0);
    send(3'd0, 32'h0000_0100, 8'h5A, 128'd0, 1'b0);
  endtask

  task automatic test_latency3();
    sel = 1'b1;
    send(3'd1, 32'h0000_0040, 8'h21, D_AAAA, 1'b0);
    send(3'd0, 32'h0000_0040, 8'h22, 128'd0, 1'b0);
  endtask

  task automatic test_backpressure();
    sel = 1'b1;
    send(3'd0, 32'h0000_0040, 8'h33, 128'd0, 1'b1);
  endtask

  // 0x41C shares index 1 with 0x10; 0x40C lands on index 0.
  task automatic test_aliasing();
    sel = 1'b0;
    send(3'd2, 32'h0000_0000, 8'h40, D0, 1'b0);
    send(3'd1, 32'h0000_0010, 8'h41, D1, 1'b0);
    send(3'd0, 32'h0000_041C, 8'h42, 128'd0, 1'b0);
    send(3'd0, 32'h0000_040C, 8'h43, 128'd0, 1'b0);
  endtask

  task automatic test_back_to_back();
    sel = 1'b0;
    send(3'd1, 32'h0000_0230, 8'h50, DX, 1'b0);
    send(3'd0, 32'h0000_0230, 8'h51, 128'd0, 1'b0);
  endtask

  task automatic test_unknown_type();
    sel = 1'b0;
    send(3'd5, 32'h0000_0000, 8'h3C, D_AAAA, 1'b0);
    send(3'd0, 32'h0000_0000, 8'h3D, 128'd0, 1'b0);
  endtask

  task automatic test_reset_mid_wait();
    int  cyc;
    bit  seen;
    sel = 1'b1;
    send(3'd2, 32'h0000_0080, 8'h60, DX, 1'b0);
    @(negedge clk);
    req_msg = {3'd0, 8'h61, 32'h0000_0080, 4'd0, 128'd0};
    req_val = 1'b1;
    cyc = 0;
    while (!dut_rdy && cyc < 50) begin
      @(negedge clk);
      cyc++;
    end
    @(posedge clk);
    #1 req_val = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    n_tests++;
    if (dut_val !== 1'b0 || dut_rdy !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_wait: val=%b rdy=%b required 0 0", dut_val, dut_rdy);
    end
    @(negedge clk);
    reset = 1'b0;
    resp_rdy = 1'b1;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (dut_val !== 1'b0) seen = 1'b1;
    end
    resp_rdy = 1'b0;
    n_tests++;
    if (seen) begin
      n_fail++;
      $display("FAIL dropped_resp: got memresp_val=1 after reset, required 0");
    end
    send(3'd0, 32'h0000_0080, 8'h62, 128'd0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_latency0();
    test_latency3();
    test_backpressure();
    test_aliasing();
    test_back_to_back();
    test_unknown_type();
    test_reset_mid_wait();
    n_tests++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_leftover: got %0d entries required 0", sb.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
